// File: rtl/i2s_rx.sv
// Slave-mode stereo I2S receiver: oversamples bclk/lrclk/data on clk_i and
// emits one left/right signed sample pair per complete, locked frame.
module i2s_rx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bclk_i,
  input  logic              lrclk_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] audio_l_o,
  output logic [DATA_W-1:0] audio_r_o,
  output logic              sample_valid_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);

  // [0]/[1] = sync stages, [2] = bclk history for edge detect
  logic [2:0] bclk_sync_q;
  logic [1:0] lr_sync_q, rx_sync_q;

  logic              bclk_rise, lr_s, rx_s, lr_change;
  logic [DATA_W:0]   shift_ext;
  logic [DATA_W-1:0] word;

  logic              lr_prev_q, lr_prev_d;
  logic              cur_ch_q, cur_ch_d;
  logic              locked_q, locked_d;
  logic              l_ok_q, l_ok_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic              err_q, err_d;
  logic              upd_d;
  // [0] = right word latched with a valid left partner, [1] = outputs updated
  logic [1:0]        vld_pipe_q;
  logic [DATA_W-1:0] audio_l_q, audio_r_q;

  assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
  assign lr_s      = lr_sync_q[1];
  assign rx_s      = rx_sync_q[1];
  assign shift_ext = {shift_q, rx_s};
  assign word      = shift_ext[DATA_W-1:0];

  always_comb begin
    lr_prev_d = lr_prev_q;
    cur_ch_d  = cur_ch_q;
    locked_d  = locked_q;
    l_ok_d    = l_ok_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    err_d     = 1'b0;
    upd_d     = 1'b0;
    lr_change = (lr_s != lr_prev_q);
    if (bclk_rise) begin
      lr_prev_d = lr_s;
      if (lr_change) begin
        // The bit under an lrclk edge is the previous slot's trailing bit.
        bit_cnt_d = '0;
        cur_ch_d  = lr_s;
        err_d     = locked_q && (bit_cnt_q < DATA_CNT);
        if (!lr_s) begin
          locked_d = 1'b1;
          l_ok_d   = 1'b0;
        end
      end else begin
        if (bit_cnt_q < DATA_CNT) shift_d = word;
        if (bit_cnt_q < SLOT_CNT) bit_cnt_d = bit_cnt_q + 1'b1;
        if ((bit_cnt_q == LAST_CNT) && locked_q) begin
          if (!cur_ch_q) begin
            hold_l_d = word;
            l_ok_d   = 1'b1;
          end else begin
            hold_r_d = word;
            // A short left slot leaves hold_l stale, so no pair this frame.
            upd_d    = l_ok_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      rx_sync_q   <= '0;
      lr_prev_q   <= 1'b0;
      cur_ch_q    <= 1'b0;
      locked_q    <= 1'b0;
      l_ok_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      err_q       <= 1'b0;
      vld_pipe_q  <= '0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], bclk_i};
      lr_sync_q   <= {lr_sync_q[0], lrclk_i};
      rx_sync_q   <= {rx_sync_q[0], rx_i};
      lr_prev_q   <= lr_prev_d;
      cur_ch_q    <= cur_ch_d;
      locked_q    <= locked_d;
      l_ok_q      <= l_ok_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      err_q       <= err_d;
      vld_pipe_q  <= {vld_pipe_q[0], upd_d};
      if (vld_pipe_q[0]) begin
        audio_l_q <= hold_l_q;
        audio_r_q <= hold_r_q;
      end
    end
  end

  assign audio_l_o      = audio_l_q;
  assign audio_r_o      = audio_r_q;
  assign sample_valid_o = vld_pipe_q[1];
  assign frame_err_o    = err_q;

endmodule
